// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - fetch stage with IF/ID pipeline register, one-entry skid buffer and opcode pre-decode
//
// clk, rst           rising-edge clock, synchronous active-high reset
// imem_req/addr      fetch request and address (address is the current PC)
// imem_ready/rdata   memory accepts the request and returns the word in the same cycle
// stall              decode cannot accept; the IF/ID register holds
// flush/redirect_pc  discard everything in flight and restart fetch at redirect_pc (word aligned)
// id_*               IF/ID register contents plus registered immediate-format select and illegal flag
module if_id_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [24:0] id_imm_field,
    output logic [2:0]  id_imm_sel,
    output logic        id_illegal
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;

    // HOLD means the skid entry is occupied; no separate full flag is needed.
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;
    logic [2:0]  skid_imm_sel;
    logic        skid_illegal;

    logic        hs;
    logic [3:0]  dec;

    // Returns {illegal, imm_sel}.
    function automatic logic [3:0] decode(input logic [6:0] opcode);
        logic [3:0] r;
        r = 4'b1_000;
        case (opcode)
            7'b0000011, 7'b0010011, 7'b1100111: r = 4'b0_000;
            7'b0100011:                         r = 4'b0_001;
            7'b1100011:                         r = 4'b0_010;
            7'b1101111:                         r = 4'b0_011;
            7'b0110111, 7'b0010111:             r = 4'b0_100;
            7'b0110011, 7'b0001111, 7'b1110011: r = 4'b0_000;
            default:                            r = 4'b1_000;
        endcase
        return r;
    endfunction

    assign imem_req     = (state_q == FETCH);
    assign imem_addr    = pc_q;
    assign hs           = imem_req & imem_ready;
    assign dec          = decode(imem_rdata[6:0]);
    assign id_imm_field = id_instr[31:7];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            id_valid     <= 1'b0;
            id_pc        <= 32'h0;
            id_instr     <= NOP_INSTR;
            id_imm_sel   <= 3'b000;
            id_illegal   <= 1'b0;
            skid_pc      <= 32'h0;
            skid_instr   <= NOP_INSTR;
            skid_imm_sel <= 3'b000;
            skid_illegal <= 1'b0;
        end else if (flush) begin
            // A handshake in this cycle is accepted by memory but its data is dropped.
            state_q    <= FETCH;
            pc_q       <= {redirect_pc[31:2], 2'b00};
            id_valid   <= 1'b0;
            id_instr   <= NOP_INSTR;
            id_imm_sel <= 3'b000;
            id_illegal <= 1'b0;
        end else begin
            case (state_q)
                BOOT: state_q <= FETCH;
                FETCH: begin
                    if (hs) begin
                        pc_q <= pc_q + 32'd4;
                        if (stall) begin
                            skid_pc      <= pc_q;
                            skid_instr   <= imem_rdata;
                            skid_imm_sel <= dec[2:0];
                            skid_illegal <= dec[3];
                            state_q      <= HOLD;
                        end else begin
                            id_valid   <= 1'b1;
                            id_pc      <= pc_q;
                            id_instr   <= imem_rdata;
                            id_imm_sel <= dec[2:0];
                            id_illegal <= dec[3];
                        end
                    end else if (!stall) begin
                        // Bubble: decode values follow the NOP so the register stays self-consistent.
                        id_valid   <= 1'b0;
                        id_instr   <= NOP_INSTR;
                        id_imm_sel <= 3'b000;
                        id_illegal <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        id_valid   <= 1'b1;
                        id_pc      <= skid_pc;
                        id_instr   <= skid_instr;
                        id_imm_sel <= skid_imm_sel;
                        id_illegal <= skid_illegal;
                        state_q    <= FETCH;
                    end
                end
                default: state_q <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - directed and randomized bench for if_id_stage against a queue-based reference model
module tb_if_id_stage;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [24:0] id_imm_field;
    logic [2:0]  id_imm_sel;
    logic        id_illegal;

    int tests = 0;
    int fails = 0;

    if_id_stage #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
        .id_imm_field(id_imm_field), .id_imm_sel(id_imm_sel), .id_illegal(id_illegal)
    );

    always #5 clk = ~clk;

    // Reference model: a PC, a booting flag, a queue of fetched-but-undelivered words and the decode-side view.
    logic [3:0]  dec_tab [128];   // {illegal, imm_sel} per opcode
    logic [31:0] m_pc;
    bit          m_boot;
    logic [31:0] q_pc [$];
    logic [31:0] q_in [$];
    logic        m_valid;
    logic [31:0] m_id_pc;
    logic [31:0] m_instr;

    function automatic logic m_req();
        return !m_boot && (q_pc.size() == 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r_rst, input logic r_ready, input logic [31:0] r_data,
                              input logic r_stall, input logic r_flush, input logic [31:0] r_redir);
        logic req;
        req = m_req();
        if (r_rst) begin
            m_pc = RPC; m_boot = 1; q_pc.delete(); q_in.delete();
            m_valid = 0; m_id_pc = 0; m_instr = NOP;
        end else if (r_flush) begin
            m_pc = {r_redir[31:2], 2'b00}; m_boot = 0; q_pc.delete(); q_in.delete();
            m_valid = 0; m_instr = NOP;
        end else if (m_boot) begin
            m_boot = 0;
        end else if (r_stall) begin
            if (req && r_ready) begin
                q_pc.push_back(m_pc); q_in.push_back(r_data); m_pc = m_pc + 4;
            end
        end else if (q_pc.size() > 0) begin
            m_valid = 1; m_id_pc = q_pc.pop_front(); m_instr = q_in.pop_front();
        end else if (req && r_ready) begin
            m_valid = 1; m_id_pc = m_pc; m_instr = r_data; m_pc = m_pc + 4;
        end else begin
            m_valid = 0; m_instr = NOP;
        end
    endtask

    task automatic step(input logic r_rst, input logic r_ready, input logic [31:0] r_data,
                        input logic r_stall, input logic r_flush, input logic [31:0] r_redir);
        logic [3:0] d;
        @(negedge clk);
        rst = r_rst; imem_ready = r_ready; imem_rdata = r_data;
        stall = r_stall; flush = r_flush; redirect_pc = r_redir;
        #1;
        chk("imem_req", imem_req, m_req());
        if (m_req()) chk("imem_addr", imem_addr, m_pc);
        @(posedge clk);
        model_edge(r_rst, r_ready, r_data, r_stall, r_flush, r_redir);
        #1;
        d = dec_tab[m_instr[6:0]];
        chk("id_valid", id_valid, m_valid);
        chk("id_instr", id_instr, m_instr);
        chk("id_imm_field", id_imm_field, m_instr[31:7]);
        if (m_valid) begin
            chk("id_pc", id_pc, m_id_pc);
            chk("id_imm_sel", id_imm_sel, d[2:0]);
            chk("id_illegal", id_illegal, d[3]);
        end
    endtask

    logic [6:0]  legal_ops [10];
    logic [31:0] rnd;
    logic [31:0] word;

    initial begin
        for (int i = 0; i < 128; i++) dec_tab[i] = 4'b1_000;
        dec_tab[7'b0000011] = 4'b0_000; dec_tab[7'b0010011] = 4'b0_000; dec_tab[7'b1100111] = 4'b0_000;
        dec_tab[7'b0100011] = 4'b0_001; dec_tab[7'b1100011] = 4'b0_010; dec_tab[7'b1101111] = 4'b0_011;
        dec_tab[7'b0110111] = 4'b0_100; dec_tab[7'b0010111] = 4'b0_100;
        dec_tab[7'b0110011] = 4'b0_000; dec_tab[7'b0001111] = 4'b0_000; dec_tab[7'b1110011] = 4'b0_000;
        legal_ops = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
                      7'b1101111, 7'b0110111, 7'b0010111, 7'b0110011, 7'b1110011};
        m_pc = RPC; m_boot = 1; m_valid = 0; m_id_pc = 0; m_instr = NOP;

        // Reset state
        step(1, 1, 32'h0, 0, 0, 32'h0);
        step(1, 1, 32'h0, 0, 0, 32'h0);
        chk("rst_valid", id_valid, 0); chk("rst_pc", id_pc, 0); chk("rst_instr", id_instr, NOP);
        chk("rst_sel", id_imm_sel, 0); chk("rst_ill", id_illegal, 0); chk("rst_req", imem_req, 0);

        // BOOT cycle, then addi / sw / jal at 0x100, 0x104, 0x108
        step(0, 1, 32'h0, 0, 0, 32'h0);
        chk("boot_addr", imem_addr, RPC);
        step(0, 1, 32'h00A0_0093, 0, 0, 32'h0);
        chk("addi_pc", id_pc, 32'h100); chk("addi_sel", id_imm_sel, 3'b000);
        step(0, 1, 32'hFE11_2E23, 0, 0, 32'h0);
        chk("sw_sel", id_imm_sel, 3'b001); chk("sw_field", id_imm_field, 25'h1FC225C);
        step(0, 1, 32'h0080_006F, 0, 0, 32'h0);
        chk("jal_sel", id_imm_sel, 3'b011); chk("jal_ill", id_illegal, 0);

        // Stall on a handshake: skid captures 0x10C, decode holds 0x108
        step(0, 1, 32'h0000_0513, 1, 0, 32'h0);
        chk("stall_hold_pc", id_pc, 32'h108);
        step(0, 1, 32'h1111_1111, 1, 0, 32'h0);
        step(0, 1, 32'h2222_2222, 0, 0, 32'h0);
        chk("skid_release_pc", id_pc, 32'h10C);
        step(0, 1, 32'h0000_0593, 0, 0, 32'h0);
        chk("resume_pc", id_pc, 32'h110);

        // Flush while in HOLD with stall high: skid entry is dropped
        step(0, 1, 32'h0000_0613, 1, 0, 32'h0);
        step(0, 1, 32'h3333_3333, 1, 1, 32'h0000_0203);
        chk("flush_valid", id_valid, 0); chk("flush_req", imem_req, 1); chk("flush_addr", imem_addr, 32'h200);
        step(0, 1, 32'h0000_0693, 0, 0, 32'h0);
        chk("post_flush_pc", id_pc, 32'h200);

        // PC wrap and ready low for three cycles
        step(0, 1, 32'h0, 0, 1, 32'hFFFF_FFFC);
        step(0, 1, 32'h0000_0713, 0, 0, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 32'h4444_4444, 0, 0, 32'h0);
            chk("nordy_addr", imem_addr, 32'h0);
        end

        // Illegal opcode
        step(0, 1, 32'h0000_007F, 0, 0, 32'h0);
        chk("ill_flag", id_illegal, 1); chk("ill_sel", id_imm_sel, 3'b000);

        // Reset in the middle of HOLD
        step(0, 1, 32'h0000_0793, 1, 0, 32'h0);
        step(1, 1, 32'h5555_5555, 1, 0, 32'h0);
        chk("rst_hold_valid", id_valid, 0); chk("rst_hold_instr", id_instr, NOP);
        chk("rst_hold_req", imem_req, 0); chk("rst_hold_addr", imem_addr, RPC);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rnd = $urandom();
            word = $urandom();
            if (rnd[1:0] != 2'b00) word[6:0] = legal_ops[$urandom_range(0, 9)];
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), word,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0), $urandom());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
